apb_multi_slave: RTL
====================

APB_MULTI_SLAVE -- requirements
Module: apb_multi_slave

Interface
REQ-001 Parameter NUM_SLV, default 3: number of APB slaves instantiated (1..4).
REQ-002 Parameter SEL_W, default 2: slave-select width.
REQ-003 Parameter ADDR_W, default 4: register address width.
REQ-004 Parameter DATA_W, default 8: data width.
REQ-005 Parameter DEPTH, default 16: registers per slave (DEPTH <= 2**ADDR_W).
REQ-006 Parameter WAIT_CYC, default 2: wait states per access when APB_WAIT_STATE_EN is defined.
REQ-007 pclk  input  1  single clock; all logic on rising edge.
REQ-008 presetn  input  1  reset, asynchronous, active-low.
REQ-009 slv_addr_in  input  SEL_W  target slave index.
REQ-010 addrin  input  ADDR_W  register address within slave.
REQ-011 datain  input  DATA_W  write data.
REQ-012 wr  input  1  1 = write, 0 = read.
REQ-013 newd  input  1  transfer request, sampled only in IDLE.
REQ-014 busy_o  output  1  high while the FSM is not in IDLE.
REQ-015 done_o  output  1  one-cycle pulse on transfer completion.
REQ-016 slverr_o  output  1  error status of last completed transfer.
REQ-017 dataout  output  DATA_W  read data of last successful read.

Function
REQ-018 Master FSM SHALL have states IDLE, SETUP, ACCESS; IDLE->SETUP on a clock edge with newd=1; SETUP->ACCESS unconditionally; ACCESS->IDLE when selected PREADY=1 or on decode error.
REQ-019 slv_addr_in, addrin, datain, wr SHALL be captured into internal registers at the IDLE->SETUP edge; later input changes SHALL not affect the transfer.
REQ-020 newd SHALL be ignored while busy_o=1; no queuing.
REQ-021 PSEL SHALL be one-hot to the captured slave in SETUP and ACCESS; PENABLE high only in ACCESS.
REQ-022 Zero-wait latency: newd sampled at edge N -> SETUP after N, ACCESS after N+1, done_o high for the cycle after edge N+2.
REQ-023 Decode error SHALL be flagged when captured slave index >= NUM_SLV, address >= DEPTH, or (simulation only) address or write data contain X/Z.
REQ-024 On decode error, no PSEL asserted, no register modified, ACCESS lasts one cycle, done_o pulses with slverr_o=1.
REQ-025 Successful write SHALL update exactly one register of one slave at ACCESS completion; slverr_o=0.
REQ-026 Successful read SHALL load dataout with the register value at completion; slverr_o=0.
REQ-027 Errored read SHALL leave dataout unchanged.
REQ-028 slverr_o SHALL update only with done_o and hold until the next completion.
REQ-029 Back-to-back: newd held high SHALL start a new transfer on the edge at which FSM is in IDLE (one IDLE cycle between transfers).

Reset
REQ-030 presetn=0 SHALL immediately force FSM to IDLE, busy_o=0, done_o=0, slverr_o=0, dataout=0, all slave registers to 0, wait counters to 0.
REQ-031 Reset mid-transfer SHALL abort it with no register write and no done_o pulse.
REQ-032 First transfer SHALL be accepted on the first edge with presetn=1 and newd=1.

Configuration
REQ-033 Macro APB_WAIT_STATE_EN defined: each slave SHALL hold PREADY low for WAIT_CYC ACCESS cycles, then high for one; done_o delayed by WAIT_CYC cycles; decode errors still complete in one ACCESS cycle.
REQ-034 Macro undefined: PREADY SHALL be high on the first ACCESS cycle; WAIT_CYC unused.

Verification
REQ-035 Reset 5 cycles, write slave 1 addr 1..9 data 5*i, read back -> dataout 5,10,...,45, slverr_o=0 each done_o.
REQ-036 Write slave 0 addr 3 = 8'hA5, write slave 2 addr 3 = 8'h5A, read both -> A5 and 5A (no aliasing).
REQ-037 Slave index 3 with NUM_SLV=3, write 8'hFF -> done_o with slverr_o=1, subsequent read of every slave addr 3 unchanged.
REQ-038 Read with addrin=4'bxx00 -> slverr_o=1, dataout holds previous value; write with datain containing X -> slverr_o=1, no write.
REQ-039 presetn low during ACCESS of write to slave 1 addr 2 -> no done_o, later read returns 0.
REQ-040 APB_WAIT_STATE_EN, WAIT_CYC=2: single write -> done_o 2 cycles later than zero-wait build, busy_o high throughout.

Source files
------------

// File: rtl/apb_multi_slave.sv
// apb_multi_slave: APB master FSM driving NUM_SLV internal register-file slaves.
// Latency: newd accepted at edge N -> done_o high for the cycle after edge N+2 (+WAIT_CYC with wait states).
// Backpressure: newd is ignored while busy_o=1; nothing is queued, the requester must retry once idle.
// Build option: define APB_WAIT_STATE_EN to make each slave insert WAIT_CYC wait states per access.
// Ports: pclk/presetn (clock, async active-low reset); slv_addr_in/addrin/datain/wr/newd (request);
//        busy_o/done_o/slverr_o/dataout (status and read data of the last completed transfer).
module apb_multi_slave #(
  parameter int NUM_SLV  = 3,
  parameter int SEL_W    = 2,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic [SEL_W-1:0]  slv_addr_in,
  input  logic [ADDR_W-1:0] addrin,
  input  logic [DATA_W-1:0] datain,
  input  logic              wr,
  input  logic              newd,
  output logic              busy_o,
  output logic              done_o,
  output logic              slverr_o,
  output logic [DATA_W-1:0] dataout
);

  // Elaboration-time sanity check of the configuration.
  if (NUM_SLV < 1 || NUM_SLV > 4 || NUM_SLV > 2**SEL_W || DEPTH > 2**ADDR_W || WAIT_CYC < 0) begin : g_bad_cfg
    $error("apb_multi_slave: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_e;

  state_e              state_q, state_d;
  logic [SEL_W-1:0]    sel_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                wr_q;
  logic                done_q, slverr_q;
  logic [DATA_W-1:0]   dataout_q;
  logic [DATA_W-1:0]   mem_q [NUM_SLV][DEPTH];

  logic                dec_err;
  logic [NUM_SLV-1:0]  psel, pready;
  logic                penable;
  logic                sel_ready;
  logic                xfer_done;
  logic [DATA_W-1:0]   rdata;

  // Decode check on the captured request; X/Z screening exists only in simulation.
  always_comb begin
    dec_err = (int'(sel_q) >= NUM_SLV) || (int'(addr_q) >= DEPTH);
`ifndef SYNTHESIS
    if ($isunknown(sel_q) || $isunknown(addr_q) || (wr_q && $isunknown(data_q))) dec_err = 1'b1;
`endif
  end

  // An errored request never selects a slave, so no register can be touched.
  always_comb begin
    for (int s = 0; s < NUM_SLV; s++) begin
      psel[s] = (state_q != S_IDLE) && !dec_err && (int'(sel_q) == s);
    end
  end
  assign penable = (state_q == S_ACCESS);

`ifdef APB_WAIT_STATE_EN
  localparam int WAIT_W = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;
  logic [WAIT_W-1:0] wait_q [NUM_SLV];

  // Each slave counts its own ACCESS cycles and raises PREADY on the (WAIT_CYC+1)-th.
  always_comb begin
    for (int s = 0; s < NUM_SLV; s++) pready[s] = (int'(wait_q[s]) == WAIT_CYC);
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int s = 0; s < NUM_SLV; s++) wait_q[s] <= '0;
    end else begin
      for (int s = 0; s < NUM_SLV; s++) begin
        if (psel[s] && penable) begin
          wait_q[s] <= pready[s] ? '0 : wait_q[s] + WAIT_W'(1);
        end
      end
    end
  end
`else
  assign pready = '1;
`endif

  always_comb begin
    sel_ready = 1'b0;
    rdata     = '0;
    for (int s = 0; s < NUM_SLV; s++) begin
      if (psel[s]) sel_ready = pready[s];
      for (int a = 0; a < DEPTH; a++) begin
        if (int'(sel_q) == s && int'(addr_q) == a) rdata = mem_q[s][a];
      end
    end
  end

  // Decode errors complete on the first ACCESS cycle without waiting for any slave.
  assign xfer_done = penable && (dec_err || sel_ready);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (newd) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (xfer_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      slverr_q  <= 1'b0;
      dataout_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= xfer_done;
      if (state_q == S_IDLE && newd) begin
        sel_q  <= slv_addr_in;
        addr_q <= addrin;
        data_q <= datain;
        wr_q   <= wr;
      end
      if (xfer_done) begin
        slverr_q <= dec_err;
        if (!dec_err && !wr_q) dataout_q <= rdata;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int s = 0; s < NUM_SLV; s++)
        for (int a = 0; a < DEPTH; a++) mem_q[s][a] <= '0;
    end else begin
      for (int s = 0; s < NUM_SLV; s++)
        for (int a = 0; a < DEPTH; a++)
          if (psel[s] && penable && pready[s] && wr_q && int'(addr_q) == a) mem_q[s][a] <= data_q;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = done_q;
  assign slverr_o = slverr_q;
  assign dataout  = dataout_q;

endmodule
